// File: rtl/gate_tt_checker.sv
// Truth-table stimulus driver and response checker for 2-input gates.
// Sweeps {a,b} through 00..11, samples y after a settle time and scores it.
module gate_tt_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       tt_expected,
    input  logic             dut_y,
    output logic             drv_a,
    output logic             drv_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic             mismatch
);

    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] CNT_RLD   = CW'(SETTLE_CYCLES);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [3:0]         tt_q, tt_d;
    logic [1:0]         drv_q, drv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [3:0]         fail_q, fail_d;
    logic               mm_q, mm_d;
    logic               miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pcnt_q  <= '0;
            tt_q    <= '0;
            drv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            tt_q    <= tt_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            mm_q    <= mm_d;
        end
    end

    // Case inequality so X/Z from a floating gate output scores as a failure.
    always_comb begin
        miss = (dut_y !== tt_q[idx_q]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        tt_d    = tt_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        mm_d    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    tt_d    = tt_expected;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    pcnt_d  = '0;
                    drv_d   = 2'b00;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_RLD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    drv_d   = 2'b00;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (miss) begin
                        fail_d[idx_q] = 1'b1;
                        mm_d          = 1'b1;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end
                    if (idx_q != 2'd3 || pcnt_q != PASS_LAST) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) pcnt_d = pcnt_q + 1'b1;
                        drv_d = idx_q + 2'd1;
                        cnt_d = CNT_RLD;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        drv_d   = 2'b00;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drv_a     = drv_q[1];
        drv_b     = drv_q[0];
        busy      = busy_q;
        done      = done_q;
        pass      = pass_q;
        err_count = err_q;
        fail_vec  = fail_q;
        mismatch  = mm_q;
    end

endmodule
